// File: rtl/pe_vec_addsub_pipe.sv
// pe_vec_addsub_pipe: two-stage valid/ready vector add/subtract PE with
// per-lane masking, optional saturation and per-lane overflow reporting.
// Optional feature macro: PE_ADDSUB_SAT_EN (present = saturation logic
// honours the sat port; absent = sat is ignored and every lane wraps).
module pe_vec_addsub_pipe #(
    parameter int unsigned NoOfElem = 16,
    parameter int unsigned wordSize = 32
) (
    input  logic                         clk,
    input  logic                         RESET,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   ctrl,
    input  logic                         sat,
    input  logic [NoOfElem-1:0]          mask,
    input  logic [NoOfElem*wordSize-1:0] a,
    input  logic [NoOfElem*wordSize-1:0] b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NoOfElem*wordSize-1:0] c,
    output logic [NoOfElem-1:0]          ovf,
    output logic [NoOfElem-1:0]          ovf_sticky,
    input  logic                         clr_sticky
);

    localparam int unsigned VecW = NoOfElem * wordSize;
    localparam int unsigned ExtW = wordSize + 2;

    localparam logic [1:0] OpAdd    = 2'b00;
    localparam logic [1:0] OpNegAdd = 2'b01;
    localparam logic [1:0] OpSub    = 2'b10;
    localparam logic [1:0] OpRevSub = 2'b11;

    localparam logic [wordSize-1:0] MaxPos = {1'b0, {(wordSize-1){1'b1}}};
    localparam logic [wordSize-1:0] MaxNeg = {1'b1, {(wordSize-1){1'b0}}};

    // Stage 1 holds the raw operands and per-beat mode.
    logic                s1_valid;
    logic [1:0]          s1_ctrl;
    logic [NoOfElem-1:0] s1_mask;
    logic [VecW-1:0]     s1_a;
    logic [VecW-1:0]     s1_b;
`ifdef PE_ADDSUB_SAT_EN
    logic                s1_sat;
`else
    logic                unused_sat;
`endif

    // Per-lane datapath results feeding stage 2.
    logic [VecW-1:0]     res_c;
    logic [NoOfElem-1:0] ovf_c;
    logic [wordSize-1:0] lane_a_c;
    logic [wordSize-1:0] lane_b_c;
    logic [ExtW-1:0]     ext_a_c;
    logic [ExtW-1:0]     ext_b_c;
    logic [ExtW-1:0]     sum_c;
    logic                lane_ovf_c;

    logic s1_adv;
    logic s2_xfer;

`ifndef PE_ADDSUB_SAT_EN
    assign unused_sat = sat;
`endif

    // Stage 1 moves to stage 2 when stage 2 is empty or draining this cycle.
    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign s2_xfer  = out_valid && out_ready;
    assign in_ready = !s1_valid || s1_adv;

    // Stage 1 register: capture operands on an input transfer.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
        if (in_valid && in_ready) begin
            s1_ctrl <= ctrl;
            s1_mask <= mask;
            s1_a    <= a;
            s1_b    <= b;
`ifdef PE_ADDSUB_SAT_EN
            s1_sat  <= sat;
`endif
        end
    end

    // Per-lane sign-extended arithmetic, overflow detect, clamp and mask.
    always_comb begin
        res_c      = '0;
        ovf_c      = '0;
        lane_a_c   = '0;
        lane_b_c   = '0;
        ext_a_c    = '0;
        ext_b_c    = '0;
        sum_c      = '0;
        lane_ovf_c = 1'b0;
        for (int i = 0; i < NoOfElem; i++) begin
            lane_a_c = s1_a[i*wordSize +: wordSize];
            lane_b_c = s1_b[i*wordSize +: wordSize];
            ext_a_c  = {{2{lane_a_c[wordSize-1]}}, lane_a_c};
            ext_b_c  = {{2{lane_b_c[wordSize-1]}}, lane_b_c};
            case (s1_ctrl)
                OpAdd:    sum_c = ext_a_c + ext_b_c;
                OpNegAdd: sum_c = ExtW'(0) - ext_a_c - ext_b_c;
                OpSub:    sum_c = ext_a_c - ext_b_c;
                OpRevSub: sum_c = ext_b_c - ext_a_c;
                default:  sum_c = '0;
            endcase
            // In range only when the top three bits are all copies of the sign.
            lane_ovf_c = (sum_c[ExtW-1:wordSize-1] != {3{sum_c[ExtW-1]}});
            if (!s1_mask[i]) begin
                res_c[i*wordSize +: wordSize] = lane_a_c;
                ovf_c[i]                      = 1'b0;
            end else begin
                res_c[i*wordSize +: wordSize] = sum_c[wordSize-1:0];
                ovf_c[i]                      = lane_ovf_c;
`ifdef PE_ADDSUB_SAT_EN
                if (s1_sat && lane_ovf_c) begin
                    res_c[i*wordSize +: wordSize] = sum_c[ExtW-1] ? MaxNeg : MaxPos;
                end
`endif
            end
        end
    end

    // Stage 2 register: result beat, held while stalled.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            out_valid <= 1'b0;
            c         <= '0;
            ovf       <= '0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            c         <= res_c;
            ovf       <= ovf_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overflow: accumulate on output transfers, clear has priority.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            ovf_sticky <= '0;
        end else if (clr_sticky) begin
            ovf_sticky <= '0;
        end else if (s2_xfer) begin
            ovf_sticky <= ovf_sticky | ovf;
        end
    end

endmodule

// File: tb/tb_pe_vec_addsub_pipe.sv
// Directed self-checking bench for pe_vec_addsub_pipe (4 lanes x 32 bits).
module tb_pe_vec_addsub_pipe;

    localparam int unsigned NE = 4;
    localparam int unsigned WS = 32;
    localparam int unsigned VW = NE * WS;

    logic          clk;
    logic          RESET;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    ctrl;
    logic          sat;
    logic [NE-1:0] mask;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] c;
    logic [NE-1:0] ovf;
    logic [NE-1:0] ovf_sticky;
    logic          clr_sticky;

    int n_vec = 0;
    int n_bad = 0;

    pe_vec_addsub_pipe #(.NoOfElem(NE), .wordSize(WS)) dut (
        .clk(clk), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
        .ctrl(ctrl), .sat(sat), .mask(mask), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .c(c), .ovf(ovf),
        .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [VW-1:0] vec4(input logic [31:0] l3, input logic [31:0] l2,
                                           input logic [31:0] l1, input logic [31:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    // Expected stream result: lane value av = k*100+l, b = 7, op = k%4.
    function automatic logic [VW-1:0] strm_exp(input int k);
        logic [VW-1:0] v;
        logic [31:0]   av;
        v = '0;
        for (int l = 0; l < NE; l++) begin
            av = 32'(k * 100 + l);
            case (k % 4)
                0:       v[l*WS +: WS] = av + 32'd7;
                1:       v[l*WS +: WS] = 32'd0 - av - 32'd7;
                2:       v[l*WS +: WS] = av - 32'd7;
                default: v[l*WS +: WS] = 32'd7 - av;
            endcase
        end
        return v;
    endfunction

    // One beat with out_ready=1; checks the two-cycle latency and returns the result.
    task automatic run_beat(input logic [1:0] op, input logic s, input logic [NE-1:0] m,
                            input logic [VW-1:0] va, input logic [VW-1:0] vb,
                            output logic [VW-1:0] rc, output logic [NE-1:0] ro);
        ctrl = op; sat = s; mask = m; a = va; b = vb;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat1_valid", VW'(out_valid), VW'(0));
        tick();
        check("lat2_valid", VW'(out_valid), VW'(1));
        rc = c;
        ro = ovf;
        tick();
    endtask

    logic [VW-1:0] rc;
    logic [NE-1:0] ro;
    logic [VW-1:0] hold_c;
    logic [VW-1:0] exp_c;
    int            idx;
    int            rx;
    bit            stall_chk;
    bit            prev_hold;
    bit            acc;
    bit            seen;

    initial begin
        RESET = 1'b0; in_valid = 1'b0; ctrl = 2'b00; sat = 1'b0; mask = '1;
        a = '0; b = '0; out_ready = 1'b0; clr_sticky = 1'b0;

        // Reset values
        tick(); tick();
        check("rst_out_valid", VW'(out_valid), VW'(0));
        check("rst_c", c, VW'(0));
        check("rst_ovf", VW'(ovf), VW'(0));
        check("rst_sticky", VW'(ovf_sticky), VW'(0));
        RESET = 1'b1;
        #1;
        check("rst_in_ready", VW'(in_ready), VW'(1));

        // Basic add: a[i]=i, b=10
        run_beat(2'b00, 1'b0, 4'hf, vec4(32'd3, 32'd2, 32'd1, 32'd0),
                 vec4(32'd10, 32'd10, 32'd10, 32'd10), rc, ro);
        check("add_c", rc, vec4(32'd13, 32'd12, 32'd11, 32'd10));
        check("add_ovf", VW'(ro), VW'(0));
        check("add_sticky", VW'(ovf_sticky), VW'(0));

        // Positive overflow, wrap
        run_beat(2'b00, 1'b0, 4'hf, {4{32'h7FFF_FFFF}}, {4{32'h0000_0001}}, rc, ro);
        check("wrap_c", rc, {4{32'h8000_0000}});
        check("wrap_ovf", VW'(ro), VW'(4'hf));
        check("wrap_sticky", VW'(ovf_sticky), VW'(4'hf));

        // Clear sticky with no transfer
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("clr_sticky", VW'(ovf_sticky), VW'(0));

        // Positive overflow with sat=1
        run_beat(2'b00, 1'b1, 4'hf, {4{32'h7FFF_FFFF}}, {4{32'h0000_0001}}, rc, ro);
`ifdef PE_ADDSUB_SAT_EN
        exp_c = {4{32'h7FFF_FFFF}};
`else
        exp_c = {4{32'h8000_0000}};
`endif
        check("sat_add_c", rc, exp_c);
        check("sat_add_ovf", VW'(ro), VW'(4'hf));

        // -a-b with a=b=min, lane 0 masked
        run_beat(2'b01, 1'b1, 4'he, {4{32'h8000_0000}}, {4{32'h8000_0000}}, rc, ro);
`ifdef PE_ADDSUB_SAT_EN
        exp_c = vec4(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000);
`else
        exp_c = vec4(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000);
`endif
        check("negadd_c", rc, exp_c);
        check("negadd_ovf", VW'(ro), VW'(4'he));

        // b-a with mask 0101
        run_beat(2'b11, 1'b0, 4'b0101, {4{32'd5}}, {4{32'd3}}, rc, ro);
        check("revsub_c", rc, vec4(32'd5, 32'hFFFF_FFFE, 32'd5, 32'hFFFF_FFFE));
        check("revsub_ovf", VW'(ro), VW'(0));

        // a-b, mixed lanes, sat=1
        run_beat(2'b10, 1'b1, 4'hf,
                 vec4(32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000),
                 vec4(32'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001), rc, ro);
`ifdef PE_ADDSUB_SAT_EN
        exp_c = vec4(32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000);
`else
        exp_c = vec4(32'h0, 32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF);
`endif
        check("sub_mix_c", rc, exp_c);
        check("sub_mix_ovf", VW'(ro), VW'(4'b0101));

        // Clear out the sticky bits from the overflow tests
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;

        // Six-beat stream with an initial downstream stall
        idx = 0; rx = 0; stall_chk = 1'b0; prev_hold = 1'b0; hold_c = '0;
        b = {4{32'd7}}; sat = 1'b0; mask = 4'hf;
        for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
            out_ready = (cyc >= 6);
            in_valid  = (idx < 6);
            ctrl      = 2'(idx % 4);
            for (int l = 0; l < NE; l++) a[l*WS +: WS] = 32'(idx * 100 + l);
            #1;
            if (prev_hold) check("stall_hold_c", c, hold_c);
            if (!out_ready && idx == 2 && !stall_chk) begin
                check("stall_in_ready", VW'(in_ready), VW'(0));
                stall_chk = 1'b1;
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check($sformatf("strm_c%0d", rx), c, strm_exp(rx));
                check($sformatf("strm_ovf%0d", rx), VW'(ovf), VW'(0));
                rx++;
            end
            prev_hold = out_valid && !out_ready;
            hold_c    = c;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("strm_count", VW'(rx), VW'(6));
        check("strm_stall_seen", VW'(stall_chk), VW'(1));

        // Clear coinciding with an overflowing output transfer
        run_beat(2'b00, 1'b0, 4'hf, {4{32'h7FFF_FFFF}}, {4{32'h1}}, rc, ro);
        check("pre_clr_sticky", VW'(ovf_sticky), VW'(4'hf));
        out_ready = 1'b0;
        ctrl = 2'b00; mask = 4'hf; a = {4{32'h7FFF_FFFF}}; b = {4{32'h1}};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("clrx_valid", VW'(out_valid), VW'(1));
        out_ready = 1'b1; clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("clrx_sticky", VW'(ovf_sticky), VW'(0));
        check("clrx_drained", VW'(out_valid), VW'(0));

        // Reset with two beats in flight
        run_beat(2'b00, 1'b0, 4'hf, {4{32'h7FFF_FFFF}}, {4{32'h1}}, rc, ro);
        out_ready = 1'b0; in_valid = 1'b1; a = {4{32'd1}}; b = {4{32'd2}};
        tick(); tick();
        in_valid = 1'b0; RESET = 1'b0;
        tick();
        check("mid_rst_valid", VW'(out_valid), VW'(0));
        check("mid_rst_c", c, VW'(0));
        check("mid_rst_ovf", VW'(ovf), VW'(0));
        check("mid_rst_sticky", VW'(ovf_sticky), VW'(0));
        RESET = 1'b1; out_ready = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_flush", VW'(seen), VW'(0));
        check("mid_rst_in_ready", VW'(in_ready), VW'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pe_vec_addsub_pipe.md
Name: pe_vec_addsub_pipe

Overview:
- Second-generation vector add/subtract processing element for the vector datapath.
- Computes per-lane signed add, negated-add, subtract or reverse-subtract on NoOfElem lanes.
- Adds valid/ready handshaking with backpressure, a two-stage pipeline, per-lane masking and per-lane overflow reporting.
- Sits between the vector register read stage and the writeback arbiter.

Parameters:
- NoOfElem, 16, number of lanes (>=1).
- wordSize, 32, lane width in bits, two's complement signed (>=2).

Ports:
- clk  in  1  clock.
- RESET  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- ctrl  in  2  00 a+b, 01 -a-b, 10 a-b, 11 b-a.
- sat  in  1  1 = saturate on overflow, 0 = wrap.
- mask  in  NoOfElem  per-lane enable; 0 = lane passes a[i].
- a  in  NoOfElem x wordSize  operand vector A.
- b  in  NoOfElem x wordSize  operand vector B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- c  out  NoOfElem x wordSize  result vector.
- ovf  out  NoOfElem  per-lane overflow flag for the current result beat.
- ovf_sticky  out  NoOfElem  accumulated overflow since reset or clear.
- clr_sticky  in  1  clears ovf_sticky.

Behaviour:
- Reset: all state updates on the rising clk edge when RESET=0. Values during reset: out_valid=0, c=0, ovf=0, ovf_sticky=0, both stages empty, in_ready=1 from the first cycle after reset.
- Reset mid-operation discards any in-flight beats. Nothing is emitted afterwards for them.
- Handshake: an input beat transfers on in_valid&in_ready; an output beat transfers on out_valid&out_ready.
- out_valid, c and ovf hold stable while out_valid=1 and out_ready=0.
- Stage S1 registers {ctrl, sat, mask, a, b}. Stage S2 registers {c, ovf}.
- S2 loads when S1 is valid and (S2 is empty or S2 transfers this cycle).
- in_ready = !S1_valid || S1 advances this cycle. No combinational path from in_valid to in_ready.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 beat/cycle while out_ready=1.
- With out_ready held 0, at most 2 beats are buffered and in_ready then drops to 0.
- Arithmetic: sign-extend a[i] and b[i] to wordSize+2 bits, then apply the ctrl operation.
  - Overflow when the extended result lies outside [-2^(wordSize-1), 2^(wordSize-1)-1].
  - Example: -a-b with a=b=min gives +2^wordSize and overflows.
- sat=0: c[i] = low wordSize bits of the result (wrap-around).
- sat=1: c[i] clamps to max positive or most negative according to the sign of the extended result.
- ovf[i] is set on overflow regardless of sat.
- Masked lane (mask[i]=0): c[i]=a[i], ovf[i]=0.
- ovf_sticky[i] |= ovf[i] only on an output transfer.
- clr_sticky=1 clears ovf_sticky. If it coincides with an output transfer, the clear wins for that cycle: the register becomes 0 and the transferring beat's flags are dropped.
- ctrl, sat and mask are sampled per beat. Mode changes between consecutive beats take effect per beat without bubbles.

Optional Feature:
- Macro PE_ADDSUB_SAT_EN.
- Defined: the saturation logic is present and the sat port behaves as described above.
- Not defined: the sat port stays in the port list but is ignored. All lanes wrap; ovf and ovf_sticky still report overflow.

Test Plan:
- Reset, then one beat ctrl=00, a[i]=i, b[i]=10, mask=all 1, out_ready=1.
  -> out_valid=1 exactly 2 cycles after transfer; c[i]=i+10; ovf=0.
- wordSize=32, ctrl=00, a=0x7FFFFFFF, b=1.
  -> sat=0: c=0x80000000, ovf=1. sat=1 (macro defined): c=0x7FFFFFFF, ovf=1. ovf_sticky bit set after the transfer.
- ctrl=01, a=b=0x80000000, sat=1.
  -> c=0x7FFFFFFF, ovf=1.
- ctrl=11, a=5, b=3, mask=0101 (NoOfElem=4).
  -> lanes 0 and 2 give 0xFFFFFFFE; lanes 1 and 3 give 5; ovf=0.
- Stream 6 back-to-back beats with out_ready=0 for cycles 2-6, then out_ready=1.
  -> in_ready=0 after 2 beats are buffered; all 6 results arrive in order with no loss or duplication; c is stable during the stall.
- Assert RESET=0 with 2 beats in flight, and separately assert clr_sticky together with an overflowing output transfer.
  -> After reset: no out_valid until new input; all outputs are 0. Clear case: ovf_sticky=0.
